// File: rtl/l2_arb_pkg.sv
// Shared types for the L2 port arbiter: master IDs and arbiter FSM states.
package l2_arb_pkg;

    typedef enum logic {
        MST_JTAG = 1'b0,
        MST_CORE = 1'b1
    } mst_id_e;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;

    function automatic mst_id_e other_mst(input mst_id_e m);
        return (m == MST_JTAG) ? MST_CORE : MST_JTAG;
    endfunction

endpackage

// File: rtl/l2_arb_id_fifo.sv
// In-order FIFO of granted master IDs; one entry per outstanding L2 transaction.
module l2_arb_id_fifo
    import l2_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    push_i,
    input  logic    pop_i,
    input  mst_id_e data_i,
    output mst_id_e data_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    mst_id_e          r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    assign full_o  = (r_count == FULL_CNT);
    assign empty_o = (r_count == '0);
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;
    assign data_o  = r_mem[r_rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage is not reset; the count alone decides which entries are valid.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= data_i;
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// Two-master (jtag, core) arbiter onto one L2 req/gnt/rvalid port.
// Define L2_ARB_JTAG_PRIO_EN for strict jtag priority instead of round-robin.
module l2_port_arbiter
    import l2_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                jtag_req_i,
    output logic                jtag_gnt_o,
    input  logic [ADDR_W-1:0]   jtag_addr_i,
    input  logic                jtag_we_i,
    input  logic [DATA_W/8-1:0] jtag_be_i,
    input  logic [DATA_W-1:0]   jtag_wdata_i,
    output logic                jtag_rvalid_o,
    output logic [DATA_W-1:0]   jtag_rdata_o,
    input  logic                core_req_i,
    output logic                core_gnt_o,
    input  logic [ADDR_W-1:0]   core_addr_i,
    input  logic                core_we_i,
    input  logic [DATA_W/8-1:0] core_be_i,
    input  logic [DATA_W-1:0]   core_wdata_i,
    output logic                core_rvalid_o,
    output logic [DATA_W-1:0]   core_rdata_o,
    output logic                l2_req_o,
    input  logic                l2_gnt_i,
    output logic [ADDR_W-1:0]   l2_addr_o,
    output logic                l2_we_o,
    output logic [DATA_W/8-1:0] l2_be_o,
    output logic [DATA_W-1:0]   l2_wdata_o,
    input  logic                l2_rvalid_i,
    input  logic [DATA_W-1:0]   l2_rdata_i,
    output logic                err_o
);

    arb_state_e r_state, w_state_nxt;
    mst_id_e    r_hold_sel, w_hold_sel_nxt;
    mst_id_e    w_arb_sel, w_sel, w_fifo_id;
    logic       w_sel_req, w_xfer, w_pop;
    logic       w_fifo_full, w_fifo_empty;
    logic       r_err;

`ifdef L2_ARB_JTAG_PRIO_EN
    assign w_arb_sel = jtag_req_i ? MST_JTAG : MST_CORE;
`else
    mst_id_e r_pref;

    // Both requesting: take the preferred one; otherwise the sole requester wins.
    assign w_arb_sel = (jtag_req_i & core_req_i) ? r_pref
                     : (jtag_req_i ? MST_JTAG : MST_CORE);

    always_ff @(posedge clk_i) begin
        if (rst_i)       r_pref <= MST_JTAG;
        else if (w_xfer) r_pref <= other_mst(w_sel);
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_ARB;
            r_hold_sel <= MST_JTAG;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_sel <= w_hold_sel_nxt;
        end
    end

    // NOTE: every signal gets a default first so no path through this block infers a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_hold_sel_nxt = r_hold_sel;
        w_sel          = (r_state == ST_HOLD) ? r_hold_sel : w_arb_sel;
        w_sel_req      = (w_sel == MST_JTAG) ? jtag_req_i : core_req_i;
        l2_req_o       = w_sel_req & ~w_fifo_full & ~rst_i;
        l2_addr_o      = (w_sel == MST_JTAG) ? jtag_addr_i  : core_addr_i;
        l2_we_o        = (w_sel == MST_JTAG) ? jtag_we_i    : core_we_i;
        l2_be_o        = (w_sel == MST_JTAG) ? jtag_be_i    : core_be_i;
        l2_wdata_o     = (w_sel == MST_JTAG) ? jtag_wdata_i : core_wdata_i;
        w_xfer         = l2_req_o & l2_gnt_i;
        jtag_gnt_o     = w_xfer & (w_sel == MST_JTAG);
        core_gnt_o     = w_xfer & (w_sel == MST_CORE);
        w_pop          = l2_rvalid_i & ~w_fifo_empty & ~rst_i;
        jtag_rvalid_o  = w_pop & (w_fifo_id == MST_JTAG);
        core_rvalid_o  = w_pop & (w_fifo_id == MST_CORE);

        unique case (r_state)
            ST_ARB: begin
                if (l2_req_o & ~l2_gnt_i) begin
                    w_state_nxt    = ST_HOLD;
                    w_hold_sel_nxt = w_sel;
                end
            end
            ST_HOLD: begin
                // A withdrawn request releases the hold rather than locking out the other master.
                if (w_xfer | ~w_sel_req) w_state_nxt = ST_ARB;
            end
            default: w_state_nxt = ST_ARB;
        endcase
    end

    assign jtag_rdata_o = l2_rdata_i;
    assign core_rdata_o = l2_rdata_i;

    l2_arb_id_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_xfer),
        .pop_i   (w_pop),
        .data_i  (w_sel),
        .data_o  (w_fifo_id),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i)                            r_err <= 1'b0;
        else if (l2_rvalid_i & w_fifo_empty)  r_err <= 1'b1;
    end

    assign err_o = r_err;

endmodule

// File: doc/l2_port_arbiter.md
L2_PORT_ARBITER -- requirements
Module: l2_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, L2 address width.
REQ-002 SHALL have parameter DATA_W, default 32, L2 data width; byte enables are DATA_W/8 bits.
REQ-003 SHALL have parameter MAX_OUTST, default 4, maximum granted-but-unanswered transactions (power of 2, >=2).
REQ-004 SHALL have port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have, per master m in {jtag, core}, ports m_req_i (in, 1), m_gnt_o (out, 1), m_addr_i (in, ADDR_W), m_we_i (in, 1), m_be_i (in, DATA_W/8), m_wdata_i (in, DATA_W), m_rvalid_o (out, 1) and m_rdata_o (out, DATA_W).
REQ-007 SHALL have L2 ports l2_req_o, l2_gnt_i, l2_addr_o, l2_we_o, l2_be_o, l2_wdata_o, l2_rvalid_i and l2_rdata_i, mirroring the master widths with directions reversed.
REQ-008 SHALL have port err_o, output, 1, sticky protocol-error flag.

Function
REQ-009 SHALL follow the req/gnt/rvalid protocol: a transaction transfers when req and gnt are both high; every transfer, read or write, returns exactly one rvalid in order, at least 1 cycle later.
REQ-010 SHALL use FSM ARB (selection free) and HOLD (selected master offered, l2_gnt_i not yet seen); HOLD has priority over re-arbitration.
REQ-011 In ARB, SHALL select by round-robin: after a jtag transfer core is preferred, after a core transfer jtag is preferred, and after reset jtag is preferred; a sole requester is always selected.
REQ-012 SHALL drive l2_req_o and the l2 address/we/be/wdata outputs combinationally from the selected master; l2_req_o=0 when no master requests or outstanding count == MAX_OUTST.
REQ-013 SHALL enter HOLD when l2_req_o=1 and l2_gnt_i=0, keep the same master selected until l2_gnt_i=1, then return to ARB.
REQ-014 SHALL assert m_gnt_o = l2_gnt_i & l2_req_o for the selected master only; the other gnt stays 0.
REQ-015 SHALL push the granted master ID into an ID FIFO on each transfer and pop it on each l2_rvalid_i; the popped ID routes rvalid to that master.
REQ-016 SHALL broadcast l2_rdata_i to both m_rdata_o; only the routed m_rvalid_o is asserted, in the same cycle as l2_rvalid_i (zero added response latency).
REQ-017 SHALL allow a push and a pop in the same cycle, leaving the count unchanged; at count == MAX_OUTST, SHALL issue no new request even if a pop occurs in that cycle.
REQ-018 SHALL set err_o on l2_rvalid_i while the FIFO is empty, drive both m_rvalid_o low in that cycle, and keep err_o set until reset.

Reset
REQ-019 On rst_i=1 at a clock edge, SHALL go to ARB, prefer jtag, empty the FIFO, clear err_o, and hold l2_req_o, both m_gnt_o and both m_rvalid_o at 0 while rst_i is high.
REQ-020 Reset mid-transaction SHALL drop outstanding IDs; a later l2_rvalid_i with an empty FIFO sets err_o per REQ-018.

Configuration
REQ-021 SHALL support macro L2_ARB_JTAG_PRIO_EN: when defined, ARB always selects jtag if jtag_req_i=1 (strict priority, round-robin pointer unused); when undefined, REQ-011 applies. HOLD behaviour is identical in both builds.

Structure
REQ-022 SHALL place the master-ID enum (MST_JTAG=0, MST_CORE=1) and the FSM state typedef in package l2_arb_pkg.
REQ-023 SHALL implement the ID FIFO as sub-module l2_arb_id_fifo (depth MAX_OUTST, 1-bit entries, push/pop/full/empty).

Verification
REQ-024 JTAG write addr 0x1C00_0000 data 0xABBAABBA, then read from the same address with an L2 model of 1-cycle latency -> jtag_rvalid_o twice, read data 0xABBAABBA, core_rvalid_o never asserted.
REQ-025 Both masters request continuously for 8 transfers, l2_gnt_i=1 -> grant sequence J,C,J,C,J,C,J,C; with L2_ARB_JTAG_PRIO_EN -> 8 jtag grants, 0 core grants.
REQ-026 Core requests with l2_gnt_i held 0 for 3 cycles while jtag asserts req in cycle 1 -> l2_addr_o remains the core address until grant and core is granted first.
REQ-027 L2 model withholds rvalid and 6 requests are issued -> 4 grants, then l2_req_o=0; one rvalid -> exactly one further grant.
REQ-028 l2_rvalid_i pulsed with the FIFO empty -> err_o=1 persists until rst_i; rst_i asserted with 2 outstanding -> count 0, outputs 0.
